// File: rtl/v3_2.sv
// v3_2: registered combinational pair.
//   E = (A & B) | (C & D)   -- product-of-pairs
//   F = A ^ B ^ C ^ D       -- 4-input odd parity
// Both outputs come straight from flops, so the latency is one clock.
// The reset is synchronous and active-low, and it overrides the
// functional update on the same edge.
module v3_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic E,
  output logic F
);

  // Odd parity over a 4-bit vector: 1 when an odd number of bits are set.
  function automatic logic parity4(input logic [3:0] v);
    return v[3] ^ v[2] ^ v[1] ^ v[0];
  endfunction

  // Product-of-pairs: true when either the AB pair or the CD pair is all ones.
  function automatic logic pair_product(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  logic [3:0] abcd_s;
  logic       e_d;
  logic       f_d;
  logic       e_q;
  logic       f_q;

  assign abcd_s = {A, B, C, D};

  // Next-state values for both result registers, taken from the current operands.
  always_comb begin
    e_d = 1'b0;
    f_d = 1'b0;
    e_d = pair_product(abcd_s);
    f_d = parity4(abcd_s);
  end

  // Result registers: the synchronous reset clears them and wins over the update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      e_q <= e_d;
      f_q <= f_d;
    end
  end

  assign E = e_q;
  assign F = f_q;

endmodule

// File: tb/tb_v3_2.sv
// Self-checking bench for v3_2: directed and randomized vectors, checked
// against a reference model built from the truth-table rules.
module tb_v3_2;

  logic clk;
  logic rst_n;
  logic A, B, C, D;
  logic E, F;

  int checks;
  int errors;

  v3_2 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .E    (E),
    .F    (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for E: 1 only for the codes 11xx and xx11.
  function automatic logic model_e(input int code);
    return ((code / 4) == 3) || ((code % 4) == 3);
  endfunction

  // Reference model for F: 1 when the count of ones is odd.
  function automatic logic model_f(input int code);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (((code >> i) & 1) == 1) ones++;
    end
    return (ones % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int code, input logic rst);
    A     = code[3];
    B     = code[2];
    C     = code[1];
    D     = code[0];
    rst_n = rst;
  endtask

  // Apply one vector, clock once, and check both outputs just after the edge.
  task automatic step(input string tag, input int code, input logic rst);
    logic exp_e, exp_f;
    drive(code, rst);
    exp_e = rst ? model_e(code) : 1'b0;
    exp_f = rst ? model_f(code) : 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_E"}, E, exp_e);
    check({tag, "_F"}, F, exp_f);
  endtask

  initial begin
    int code;
    logic rst;
    checks = 0;
    errors = 0;
    drive(15, 1'b0);

    // Reset held low for two edges with all operands high.
    step("rst0", 15, 1'b0);
    step("rst1", 15, 1'b0);

    // Directed vectors after release, with hand-derived expectations.
    drive(0, 1'b1);  @(posedge clk); #1; check("dir0000_E", E, 1'b0); check("dir0000_F", F, 1'b0);
    drive(5, 1'b1);  @(posedge clk); #1; check("dir0101_E", E, 1'b0); check("dir0101_F", F, 1'b0);
    drive(10, 1'b1); @(posedge clk); #1; check("dir1010_E", E, 1'b0); check("dir1010_F", F, 1'b0);
    drive(12, 1'b1); @(posedge clk); #1; check("dir1100_E", E, 1'b1); check("dir1100_F", F, 1'b0);
    drive(14, 1'b1); @(posedge clk); #1; check("dir1110_E", E, 1'b1); check("dir1110_F", F, 1'b1);
    drive(15, 1'b1); @(posedge clk); #1; check("dir1111_E", E, 1'b1); check("dir1111_F", F, 1'b0);

    // Exhaustive sweep over all 16 codes.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), i, 1'b1);
    end

    // Latency: an operand change mid-cycle must not show until the next edge.
    step("lat_pre", 0, 1'b1);
    #3;
    drive(3, 1'b1);
    #1;
    check("lat_hold_E", E, 1'b0);
    check("lat_hold_F", F, 1'b0);
    @(posedge clk);
    #1;
    check("lat_post_E", E, 1'b1);
    check("lat_post_F", F, 1'b0);

    // Mid-run reset with ABCD = 1000.
    step("mid_run", 8, 1'b1);
    check("mid_run_Fhigh", F, 1'b1);
    step("mid_rst", 8, 1'b0);
    step("mid_rel", 8, 1'b1);

    // Randomized vectors with occasional reset pulses.
    for (int n = 0; n < 200; n++) begin
      code = $urandom_range(15, 0);
      rst  = ($urandom_range(7, 0) != 0);
      step("rand", code, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v3_2.md
V3_2 -- requirements
Module: v3_2

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-004 A  input  1  logic operand A.
REQ-005 B  input  1  logic operand B.
REQ-006 C  input  1  logic operand C.
REQ-007 D  input  1  logic operand D.
REQ-008 E  output  1  registered product-of-pairs result.
REQ-009 F  output  1  registered 4-input odd-parity result.

Function
REQ-010 The next value of E SHALL be (A AND B) OR (C AND D), evaluated on the A..D values sampled at the rising clk edge.
REQ-011 The next value of F SHALL be A XOR B XOR C XOR D, evaluated on the same sampled values.
REQ-012 E and F SHALL be driven directly from flip-flops, with no combinational path from A..D to E/F.
REQ-013 Latency SHALL be exactly 1 cycle: inputs present before rising edge N appear on E/F immediately after edge N and hold until edge N+1.
REQ-014 Input changes between clock edges SHALL have no effect on E/F until the next rising edge.
REQ-015 All 16 input combinations SHALL be legal; the block has no don't-care input codes.
REQ-016 X/Z on any input is not a supported operating condition; behaviour for those values is unspecified.
REQ-017 Full truth table; E = 1 only for: 11xx, xx11.
REQ-018 Full truth table; F = 1 for an odd number of ones among A, B, C, D.
REQ-019 The block SHALL hold no state other than the E and F registers.

Reset
REQ-020 When rst_n = 0 at a rising clk edge, E and F SHALL both become 0, regardless of A..D.
REQ-021 Reset SHALL take priority over functional update in the same cycle.
REQ-022 While rst_n is held low, E and F SHALL remain 0.
REQ-023 On the first rising edge with rst_n = 1, the outputs SHALL reflect the inputs sampled at that edge (REQ-010, REQ-011).
REQ-024 Asserting rst_n low mid-operation SHALL clear E and F at the next rising edge with no other side effect.
REQ-025 Before the first clock edge, the output value is undefined.

Verification
REQ-026 Reset scenario: hold rst_n = 0 for 2 cycles with A..D = 1111 -> E = 0 and F = 0 after each edge.
REQ-027 Directed vector scenario: release reset, then apply one vector per cycle and check after each edge:
- 0000 -> E=0, F=0
- 0101 -> E=0, F=0
- 1010 -> E=0, F=0
- 1100 -> E=1, F=0
- 1110 -> E=1, F=1
- 1111 -> E=1, F=0
REQ-028 Exhaustive scenario: sweep all 16 ABCD codes, one per cycle -> each output matches REQ-010/REQ-011 one cycle later.
REQ-029 Latency scenario: change ABCD from 0000 to 0011 mid-cycle -> E stays 0 until the next rising edge, then becomes 1, with F = 0.
REQ-030 Mid-run reset scenario: with ABCD = 1000 (F=1), drive rst_n = 0 for 1 cycle -> E=0 and F=0. Release rst_n -> F=1 again one edge later.
